// File: rtl/ui_pkg.sv
// Shared UI types: scheduler state encoding, pixel widths, shape indices.
package ui_pkg;

  localparam int UI_X_W      = 8;
  localparam int UI_Y_W      = 7;
  localparam int UI_COLOUR_W = 3;

  typedef enum logic [1:0] {
    SHAPE_UP    = 2'd0,
    SHAPE_DOWN  = 2'd1,
    SHAPE_LEFT  = 2'd2,
    SHAPE_RIGHT = 2'd3
  } ui_shape_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_START  = 3'd2,
    ST_DRAW   = 3'd3,
    ST_FINISH = 3'd4
  } ui_state_e;

endpackage

// File: rtl/ui_watchdog_counter.sv
// Cycle counter with clear/enable that saturates on its terminal count.
module ui_watchdog_counter #(
  parameter int TERM = 62500000,
  parameter int W    = $clog2(TERM + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == W'(TERM - 1));

endmodule

// File: rtl/ui_draw_scheduler.sv
// Shares the vga_adapter pixel port among the arrow drawers, one command at a time.
// Define UI_CLEAR_EN to blank a fixed box before each shape is drawn.
module ui_draw_scheduler
  import ui_pkg::*;
#(
  parameter int NUM_SHAPES  = 4,
  parameter int SEL_W       = 2,
  parameter int X_W         = UI_X_W,
  parameter int Y_W         = UI_Y_W,
  parameter int COLOUR_W    = UI_COLOUR_W,
  parameter int TIMEOUT_CYC = 62500000,
  parameter int CLR_X0      = 72,
  parameter int CLR_Y0      = 56,
  parameter int CLR_W       = 16,
  parameter int CLR_H       = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [SEL_W-1:0]          cmd_shape,
  input  logic [COLOUR_W-1:0]       cmd_colour,
  output logic [NUM_SHAPES-1:0]     drw_start,
  input  logic [NUM_SHAPES*X_W-1:0] drw_x,
  input  logic [NUM_SHAPES*Y_W-1:0] drw_y,
  input  logic [NUM_SHAPES-1:0]     drw_plot,
  input  logic [NUM_SHAPES-1:0]     drw_done,
  output logic [X_W-1:0]            vga_x,
  output logic [Y_W-1:0]            vga_y,
  output logic [COLOUR_W-1:0]       vga_colour,
  output logic                      vga_plot,
  output logic                      busy,
  output logic                      draw_done,
  output logic                      timeout_err,
  output logic                      bad_cmd
);

  ui_state_e             r_state;
  ui_state_e             w_next;
  logic [SEL_W-1:0]      r_shape;
  logic [COLOUR_W-1:0]   r_colour;
  logic [X_W-1:0]        r_vga_x;
  logic [Y_W-1:0]        r_vga_y;
  logic                  r_vga_plot;
  logic                  r_timeout;
  logic                  r_bad;
  logic                  w_cmd_ok;
  logic                  w_tc;
  logic                  w_sel_done;
  logic                  w_clr_act;
  logic                  w_clr_last;
  logic [X_W-1:0]        w_clr_x;
  logic [Y_W-1:0]        w_clr_y;
  logic [X_W-1:0]        w_sel_x;
  logic [Y_W-1:0]        w_sel_y;
  logic                  w_sel_plot;

  assign w_cmd_ok   = int'(cmd_shape) < NUM_SHAPES;
  assign w_sel_x    = drw_x[int'(r_shape)*X_W +: X_W];
  assign w_sel_y    = drw_y[int'(r_shape)*Y_W +: Y_W];
  assign w_sel_plot = drw_plot[r_shape];
  assign w_sel_done = drw_done[r_shape];
  assign w_clr_act  = (r_state == ST_CLEAR);

`ifdef UI_CLEAR_EN
  logic [$clog2(CLR_W+1)-1:0] r_cx;
  logic [$clog2(CLR_H+1)-1:0] r_cy;
  logic                       w_row_end;

  assign w_row_end  = (r_cx == $bits(r_cx)'(CLR_W - 1));
  assign w_clr_last = w_row_end && (r_cy == $bits(r_cy)'(CLR_H - 1));
  assign w_clr_x    = X_W'(CLR_X0) + X_W'(r_cx);
  assign w_clr_y    = Y_W'(CLR_Y0) + Y_W'(r_cy);

  always_ff @(posedge clk) begin
    if (!reset_n || !w_clr_act) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (w_row_end) begin
      r_cx <= '0;
      r_cy <= r_cy + 1'b1;
    end else begin
      r_cx <= r_cx + 1'b1;
    end
  end
`else
  // CLEAR is unreachable here; these only tie off the box constants.
  assign w_clr_last = (CLR_W > 0) && (CLR_H > 0);
  assign w_clr_x    = X_W'(CLR_X0);
  assign w_clr_y    = Y_W'(CLR_Y0);
`endif

  ui_watchdog_counter #(
    .TERM (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (r_state == ST_START),
    .i_en    (r_state == ST_DRAW),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid && w_cmd_ok) begin
`ifdef UI_CLEAR_EN
          w_next = ST_CLEAR;
`else
          w_next = ST_START;
`endif
        end
      end
      ST_CLEAR:  if (w_clr_last) w_next = ST_START;
      ST_START:  w_next = ST_DRAW;
      ST_DRAW:   if (w_sel_done || w_tc) w_next = ST_FINISH;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_shape    <= '0;
      r_colour   <= '0;
      r_vga_x    <= '0;
      r_vga_y    <= '0;
      r_vga_plot <= 1'b0;
      r_timeout  <= 1'b0;
      r_bad      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && cmd_valid) begin
        if (w_cmd_ok) begin
          r_shape  <= cmd_shape;
          r_colour <= cmd_colour;
        end else begin
          r_bad <= 1'b1;
        end
      end
      if (r_state == ST_DRAW && w_tc && !w_sel_done) begin
        r_timeout <= 1'b1;
      end
      // Drawer pixels are re-timed by one cycle; clear pixels go out direct.
      if (r_state == ST_DRAW) begin
        r_vga_x    <= w_sel_x;
        r_vga_y    <= w_sel_y;
        r_vga_plot <= w_sel_plot;
      end else if (w_clr_act) begin
        r_vga_x    <= w_clr_x;
        r_vga_y    <= w_clr_y;
        r_vga_plot <= 1'b0;
      end else begin
        r_vga_plot <= 1'b0;
      end
    end
  end

  always_comb begin
    drw_start = '0;
    if (r_state == ST_START) drw_start[r_shape] = 1'b1;
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign draw_done   = (r_state == ST_FINISH);
  assign timeout_err = r_timeout;
  assign bad_cmd     = r_bad;
  assign vga_x       = w_clr_act ? w_clr_x : r_vga_x;
  assign vga_y       = w_clr_act ? w_clr_y : r_vga_y;
  assign vga_colour  = w_clr_act ? '0 : r_colour;
  assign vga_plot    = w_clr_act || (r_state == ST_DRAW && r_vga_plot);

endmodule

// File: tb/tb_ui_draw_scheduler.sv
// Directed bench for ui_draw_scheduler: 3 drawers, 100-cycle watchdog, 4x2 clear box.
module tb_ui_draw_scheduler;

  localparam int NS = 3;
  localparam int SW = 2;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [SW-1:0]    cmd_shape = '0;
  logic [CW-1:0]    cmd_colour = '0;
  logic [NS-1:0]    drw_start;
  logic [NS*XW-1:0] drw_x;
  logic [NS*YW-1:0] drw_y;
  logic [NS-1:0]    drw_plot;
  logic [NS-1:0]    drw_done;
  logic [XW-1:0]    vga_x;
  logic [YW-1:0]    vga_y;
  logic [CW-1:0]    vga_colour;
  logic             vga_plot;
  logic             busy;
  logic             draw_done;
  logic             timeout_err;
  logic             bad_cmd;

  logic [XW-1:0] d_x [NS];
  logic [YW-1:0] d_y [NS];
  logic [NS-1:0] d_plot = '0;
  logic [NS-1:0] d_done = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_comb begin
    drw_x = '0;
    drw_y = '0;
    for (int i = 0; i < NS; i++) begin
      drw_x[i*XW +: XW] = d_x[i];
      drw_y[i*YW +: YW] = d_y[i];
    end
  end
  assign drw_plot = d_plot;
  assign drw_done = d_done;

  ui_draw_scheduler #(
    .NUM_SHAPES  (NS),
    .SEL_W       (SW),
    .X_W         (XW),
    .Y_W         (YW),
    .COLOUR_W    (CW),
    .TIMEOUT_CYC (100),
    .CLR_X0      (10),
    .CLR_Y0      (20),
    .CLR_W       (4),
    .CLR_H       (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_shape   (cmd_shape),
    .cmd_colour  (cmd_colour),
    .drw_start   (drw_start),
    .drw_x       (drw_x),
    .drw_y       (drw_y),
    .drw_plot    (drw_plot),
    .drw_done    (drw_done),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .busy        (busy),
    .draw_done   (draw_done),
    .timeout_err (timeout_err),
    .bad_cmd     (bad_cmd)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_drawers;
    d_plot = '0;
    d_done = '0;
    for (int i = 0; i < NS; i++) begin
      d_x[i] = '0;
      d_y[i] = '0;
    end
  endtask

  // Issue a command and stop in the first DRAW cycle.
  task automatic enter_draw(input logic [SW-1:0] s, input logic [CW-1:0] c);
    logic [NS-1:0] exp;
    exp = '0;
    exp[s] = 1'b1;
    cmd_valid = 1'b1;
    cmd_shape = s;
    cmd_colour = c;
    step;
    cmd_valid = 1'b0;
`ifdef UI_CLEAR_EN
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (vga_plot !== 1'b1 || vga_x !== XW'(10 + k % 4) ||
          vga_y !== YW'(20 + k / 4) || vga_colour !== 3'd0 ||
          drw_start !== 3'b000) begin
        fails++;
        $display("FAIL clear_px%0d got plot=%b (%0d,%0d) col=%0d start=%b exp plot=1 (%0d,%0d) col=0 start=000",
                 k, vga_plot, vga_x, vga_y, vga_colour, drw_start, 10 + k % 4, 20 + k / 4);
      end
      step;
    end
`endif
    tests++;
    if (drw_start !== exp || busy !== 1'b1 || cmd_ready !== 1'b0 || vga_plot !== 1'b0) begin
      fails++;
      $display("FAIL start_pulse got start=%b busy=%b ready=%b plot=%b exp start=%b busy=1 ready=0 plot=0",
               drw_start, busy, cmd_ready, vga_plot, exp);
    end
    step;
    tests++;
    if (drw_start !== 3'b000 || vga_plot !== 1'b0) begin
      fails++;
      $display("FAIL start_once got start=%b plot=%b exp start=000 plot=0", drw_start, vga_plot);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    clr_drawers();
    step;
    step;
    reset_n = 1'b1;
    step;
    tests++;
    if ({cmd_ready, busy, vga_plot, draw_done, timeout_err, bad_cmd, drw_start} !== 9'b1_00000_000 ||
        vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'd0) begin
      fails++;
      $display("FAIL reset got rdy=%b busy=%b plot=%b done=%b to=%b bad=%b start=%b x=%0d y=%0d col=%0d exp rdy=1 rest 0",
               cmd_ready, busy, vga_plot, draw_done, timeout_err, bad_cmd, drw_start, vga_x, vga_y, vga_colour);
    end
  endtask

  task automatic test_basic;
    enter_draw(2'd0, 3'b100);
    for (int k = 0; k < 8; k++) begin
      d_plot[0] = 1'b1;
      d_x[0] = 8'd79;
      d_y[0] = YW'(63 + k);
      step;
      tests++;
      if (vga_plot !== 1'b1 || vga_x !== 8'd79 || vga_y !== YW'(63 + k) ||
          vga_colour !== 3'b100 || draw_done !== 1'b0) begin
        fails++;
        $display("FAIL basic_px%0d got plot=%b (%0d,%0d) col=%b done=%b exp plot=1 (79,%0d) col=100 done=0",
                 k, vga_plot, vga_x, vga_y, vga_colour, draw_done, 63 + k);
      end
    end
    d_plot[0] = 1'b0;
    d_done[0] = 1'b1;
    step;
    tests++;
    if (draw_done !== 1'b1 || vga_plot !== 1'b0 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_finish got done=%b plot=%b ready=%b exp done=1 plot=0 ready=0",
               draw_done, vga_plot, cmd_ready);
    end
    d_done[0] = 1'b0;
    step;
    tests++;
    if (draw_done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 ||
        vga_x !== 8'd79 || vga_y !== 7'd70) begin
      fails++;
      $display("FAIL basic_idle got done=%b ready=%b busy=%b (%0d,%0d) exp done=0 ready=1 busy=0 (79,70)",
               draw_done, cmd_ready, busy, vga_x, vga_y);
    end
    clr_drawers();
  endtask

  task automatic test_select;
    enter_draw(2'd2, 3'b011);
    d_plot[1] = 1'b1;
    d_done[1] = 1'b1;
    d_x[1] = 8'd1;
    d_y[1] = 7'd1;
    for (int k = 0; k < 3; k++) begin
      step;
      tests++;
      if (vga_plot !== 1'b0 || draw_done !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL select_ignore%0d got plot=%b done=%b busy=%b exp plot=0 done=0 busy=1",
                 k, vga_plot, draw_done, busy);
      end
    end
    d_plot[2] = 1'b1;
    d_x[2] = 8'd5;
    d_y[2] = 7'd6;
    step;
    tests++;
    if (vga_plot !== 1'b1 || vga_x !== 8'd5 || vga_y !== 7'd6 || vga_colour !== 3'b011) begin
      fails++;
      $display("FAIL select_px got plot=%b (%0d,%0d) col=%b exp plot=1 (5,6) col=011",
               vga_plot, vga_x, vga_y, vga_colour);
    end
    d_plot[2] = 1'b0;
    d_done[2] = 1'b1;
    step;
    tests++;
    if (draw_done !== 1'b1 || vga_plot !== 1'b0) begin
      fails++;
      $display("FAIL select_finish got done=%b plot=%b exp done=1 plot=0", draw_done, vga_plot);
    end
    clr_drawers();
    step;
    tests++;
    if (cmd_ready !== 1'b1 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL select_idle got ready=%b to=%b exp ready=1 to=0", cmd_ready, timeout_err);
    end
  endtask

  task automatic test_timeout;
    int n;
    enter_draw(2'd0, 3'b001);
    n = 0;
    while (draw_done !== 1'b1 && n < 200) begin
      step;
      n++;
    end
    tests++;
    if (n != 100 || timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout got cycles=%0d to=%b exp cycles=100 to=1", n, timeout_err);
    end
    step;
    tests++;
    if (cmd_ready !== 1'b1 || draw_done !== 1'b0 || timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_idle got ready=%b done=%b to=%b exp ready=1 done=0 to=1",
               cmd_ready, draw_done, timeout_err);
    end
  endtask

  task automatic test_bad_cmd;
    cmd_valid = 1'b1;
    cmd_shape = 2'd3;
    cmd_colour = 3'b111;
    step;
    cmd_valid = 1'b0;
    tests++;
    if (bad_cmd !== 1'b1 || drw_start !== 3'b000 || busy !== 1'b0 ||
        draw_done !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL bad_cmd got bad=%b start=%b busy=%b done=%b ready=%b exp bad=1 start=000 busy=0 done=0 ready=1",
               bad_cmd, drw_start, busy, draw_done, cmd_ready);
    end
    step;
    tests++;
    if (bad_cmd !== 1'b1 || drw_start !== 3'b000 || draw_done !== 1'b0) begin
      fails++;
      $display("FAIL bad_cmd_hold got bad=%b start=%b done=%b exp bad=1 start=000 done=0",
               bad_cmd, drw_start, draw_done);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int dones;
    int exp_n;
`ifdef UI_CLEAR_EN
    exp_n = 12;
`else
    exp_n = 4;
`endif
    cmd_valid = 1'b1;
    cmd_shape = 2'd0;
    cmd_colour = 3'b010;
    n = 0;
    do begin
      step;
      n++;
    end while (drw_start === 3'b000 && n < 30);
    tests++;
    if (drw_start !== 3'b001) begin
      fails++;
      $display("FAIL b2b_first got start=%b exp 001", drw_start);
    end
    cmd_shape = 2'd1;
    d_done[0] = 1'b1;
    n = 0;
    dones = 0;
    do begin
      step;
      n++;
      if (draw_done === 1'b1) dones++;
    end while (drw_start === 3'b000 && n < 30);
    tests++;
    if (drw_start !== 3'b010 || n != exp_n || dones != 1) begin
      fails++;
      $display("FAIL b2b_second got start=%b cycles=%0d dones=%0d exp start=010 cycles=%0d dones=1",
               drw_start, n, dones, exp_n);
    end
    cmd_valid = 1'b0;
    d_done = 3'b010;
    step;
    step;
    tests++;
    if (draw_done !== 1'b1 || vga_colour !== 3'b010) begin
      fails++;
      $display("FAIL b2b_finish got done=%b col=%b exp done=1 col=010", draw_done, vga_colour);
    end
    clr_drawers();
    step;
  endtask

  task automatic test_reset_mid;
    enter_draw(2'd1, 3'b101);
    d_plot[1] = 1'b1;
    d_x[1] = 8'd50;
    d_y[1] = 7'd40;
    step;
    tests++;
    if (vga_plot !== 1'b1 || vga_x !== 8'd50 || vga_y !== 7'd40) begin
      fails++;
      $display("FAIL mid_px got plot=%b (%0d,%0d) exp plot=1 (50,40)", vga_plot, vga_x, vga_y);
    end
    reset_n = 1'b0;
    step;
    tests++;
    if ({cmd_ready, busy, vga_plot, draw_done, timeout_err, bad_cmd, drw_start} !== 9'b1_00000_000 ||
        vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'd0) begin
      fails++;
      $display("FAIL mid_reset got rdy=%b busy=%b plot=%b done=%b to=%b bad=%b start=%b x=%0d y=%0d col=%0d exp rdy=1 rest 0",
               cmd_ready, busy, vga_plot, draw_done, timeout_err, bad_cmd, drw_start, vga_x, vga_y, vga_colour);
    end
    reset_n = 1'b1;
    clr_drawers();
    step;
    tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || draw_done !== 1'b0) begin
      fails++;
      $display("FAIL mid_after got ready=%b busy=%b done=%b exp ready=1 busy=0 done=0",
               cmd_ready, busy, draw_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_select();
    test_timeout();
    test_bad_cmd();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got still running exp finished");
    $fatal(1, "bench did not finish");
  end

endmodule
